dmem_responder: RTL and testbench

//   Responder end of the processor data-memory interface: accepts load/store

---
 rtl/dmem_responder.sv | 136 +++++++++++++
 tb/tb_dmem_responder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: posted-store write buffer with load forwarding
// in front of a word-addressed array with fixed read latency.
module dmem_responder #(
   parameter int ADDR_W   = 12,
   parameter int WB_DEPTH = 4,
   parameter int READ_LAT = 2
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      req_valid,
   input  logic                      req_wren,
   input  logic [ADDR_W-1:0]         req_addr,
   input  logic [31:0]               req_data,
   output logic                      req_ready,
   output logic                      resp_valid,
   output logic [31:0]               resp_data,
   output logic [$clog2(WB_DEPTH):0] wb_count,
   output logic                      busy
);

   localparam int PTR_W = $clog2(WB_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

   typedef enum logic {
      IDLE,
      RD_WAIT
   } state_t;

   logic [31:0]       mem     [2**ADDR_W];
   logic [ADDR_W-1:0] wb_addr [WB_DEPTH];
   logic [31:0]       wb_data [WB_DEPTH];

   state_t            state;
   logic [PTR_W-1:0]  head;
   logic [PTR_W-1:0]  tail;
   logic [CNT_W-1:0]  count;
   logic [LAT_W-1:0]  cnt;
   logic [ADDR_W-1:0] rd_addr;

   logic              full;
   logic              accept;
   logic              st_acc;
   logic              ld_acc;
   logic              drain;
   logic              hit;
   logic [31:0]       hit_data;

   assign full     = (count == CNT_W'(WB_DEPTH));
   assign accept   = req_valid & req_ready;
   assign st_acc   = accept & req_wren;
   assign ld_acc   = accept & ~req_wren;
   assign drain    = ~accept & (count != '0);
   assign wb_count = count;
   assign busy     = (state != IDLE) || (count != '0);

   always_comb begin
      req_ready = (state == IDLE) && !(req_wren && full);
   end

   // Walk oldest to newest so the last match is the youngest store.
   always_comb begin
      logic [PTR_W-1:0] idx;
      idx      = '0;
      hit      = 1'b0;
      hit_data = '0;
      for (int k = 0; k < WB_DEPTH; k++) begin
         idx = head + PTR_W'(k);
         if ((CNT_W'(k) < count) && (wb_addr[idx] == req_addr)) begin
            hit      = 1'b1;
            hit_data = wb_data[idx];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (st_acc) begin
         wb_addr[tail] <= req_addr;
         wb_data[tail] <= req_data;
      end
      if (drain) begin
         mem[wb_addr[head]] <= wb_data[head];
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         cnt        <= '0;
         rd_addr    <= '0;
         resp_valid <= 1'b0;
         resp_data  <= '0;
      end else begin
         resp_valid <= 1'b0;
         if (st_acc) begin
            tail  <= tail + 1'b1;
            count <= count + 1'b1;
         end else if (drain) begin
            head  <= head + 1'b1;
            count <= count - 1'b1;
         end
         unique case (state)
            IDLE: begin
               if (ld_acc) begin
                  if (hit) begin
                     resp_valid <= 1'b1;
                     resp_data  <= hit_data;
                  end else if (READ_LAT == 1) begin
                     resp_valid <= 1'b1;
                     resp_data  <= mem[req_addr];
                  end else begin
                     state   <= RD_WAIT;
                     cnt     <= LAT_W'(READ_LAT - 1);
                     rd_addr <= req_addr;
                  end
               end
            end
            RD_WAIT: begin
               // A miss has no buffered match, so drains cannot alter rd_addr.
               if (cnt == LAT_W'(1)) begin
                  resp_valid <= 1'b1;
                  resp_data  <= mem[rd_addr];
                  state      <= IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: request table driven into a scoreboard that
// models the write buffer, read latency and response data.
module tb_dmem_responder;

   localparam int ADDR_W   = 12;
   localparam int WB_DEPTH = 4;
   localparam int READ_LAT = 2;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_wren = 1'b0;
   logic [11:0] req_addr = '0;
   logic [31:0] req_data = '0;
   logic        req_ready;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic [2:0]  wb_count;
   logic        busy;

   dmem_responder #(
      .ADDR_W   (ADDR_W),
      .WB_DEPTH (WB_DEPTH),
      .READ_LAT (READ_LAT)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_wren   (req_wren),
      .req_addr   (req_addr),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_data  (resp_data),
      .wb_count   (wb_count),
      .busy       (busy)
   );

   always #5 clock = ~clock;

   typedef struct {
      bit          wren;
      logic [11:0] addr;
      logic [31:0] data;
      logic [31:0] exp;
      int          gap;
   } vec_t;

   typedef struct {
      logic [31:0] data;
      int          due;
   } exp_t;

   exp_t        eq[$];
   logic [11:0] wbq[$];
   int          m_wait = 0;
   int          cyc = 0;
   logic [31:0] last_data = '0;
   bit          last_acc = 1'b0;
   logic [31:0] cur_exp = '0;
   int          tests = 0;
   int          fails = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit in_wb(logic [11:0] a);
      foreach (wbq[i]) if (wbq[i] == a) return 1'b1;
      return 1'b0;
   endfunction

   always @(negedge reset) begin
      eq.delete();
      wbq.delete();
      m_wait    = 0;
      last_data = '0;
   end

   always begin : model_p
      bit rdy;
      bit acc;
      @(posedge clock);
      cyc++;
      last_acc = 1'b0;
      if (reset) begin
         rdy = (m_wait == 0) && !(req_wren && wbq.size() == WB_DEPTH);
         acc = req_valid && rdy;
         if (m_wait > 0) m_wait--;
         if (acc && req_wren) begin
            wbq.push_back(req_addr);
         end else if (acc) begin
            if (in_wb(req_addr)) begin
               eq.push_back('{cur_exp, cyc});
            end else begin
               eq.push_back('{cur_exp, cyc + READ_LAT - 1});
               m_wait = READ_LAT - 1;
            end
         end else if (wbq.size() > 0) begin
            void'(wbq.pop_front());
         end
         last_acc = acc;
      end
   end

   always begin : ready_p
      @(negedge clock);
      chk("req_ready", 32'(req_ready),
          32'((m_wait == 0) && !(req_wren && wbq.size() == WB_DEPTH)));
   end

   always begin : check_p
      bit ev;
      @(posedge clock);
      #1;
      ev = (eq.size() > 0) && (eq[0].due == cyc);
      if (ev) begin
         last_data = eq[0].data;
         void'(eq.pop_front());
      end
      chk("resp_valid", 32'(resp_valid), 32'(ev));
      chk("resp_data", resp_data, last_data);
      chk("wb_count", 32'(wb_count), 32'(wbq.size()));
      chk("busy", 32'(busy), 32'((m_wait != 0) || (wbq.size() != 0)));
   end

   task automatic idle(int n);
      req_valid = 1'b0;
      repeat (n) @(posedge clock);
      #2;
   endtask

   task automatic apply(vec_t v);
      int n;
      req_valid = 1'b1;
      req_wren  = v.wren;
      req_addr  = v.addr;
      req_data  = v.data;
      cur_exp   = v.exp;
      n = 0;
      do begin
         @(posedge clock);
         #1;
         n++;
      end while (!last_acc && n < 20);
      #1;
      tests++;
      if (!last_acc) begin
         fails++;
         $display("FAIL accept_timeout: addr %h not accepted after %0d cycles", v.addr, n);
      end
      req_valid = 1'b0;
      if (v.gap > 0) idle(v.gap);
   endtask

   vec_t tbl_a[$];
   vec_t tbl_b[$];

   initial begin
      tbl_a.push_back('{1'b1, 12'h010, 32'hDEADBEEF, 32'h0, 2});
      tbl_a.push_back('{1'b0, 12'h010, 32'h0, 32'hDEADBEEF, 2});
      tbl_a.push_back('{1'b1, 12'h020, 32'h1, 32'h0, 0});
      tbl_a.push_back('{1'b1, 12'h020, 32'h2, 32'h0, 0});
      tbl_a.push_back('{1'b0, 12'h020, 32'h0, 32'h2, 4});
      for (int i = 0; i < 5; i++)
         tbl_a.push_back('{1'b1, 12'h030 + 12'(i), 32'h300 + 32'(i), 32'h0, 0});
      for (int i = 0; i < 5; i++)
         tbl_a.push_back('{1'b0, 12'h030 + 12'(i), 32'h0, 32'h300 + 32'(i), 0});
      tbl_a.push_back('{1'b0, 12'h020, 32'h0, 32'h2, 6});

      for (int i = 0; i < 12; i++)
         tbl_b.push_back('{1'b1, 12'h100 + 12'(i * 3), 32'hC0DE0000 + 32'(i * 257),
                           32'h0, (i % 3 == 2) ? 2 : 0});
      for (int i = 0; i < 12; i++)
         tbl_b.push_back('{1'b0, 12'h100 + 12'(i * 3), 32'h0,
                           32'hC0DE0000 + 32'(i * 257), 0});

      reset = 1'b0;
      repeat (3) @(posedge clock);
      #2;
      reset = 1'b1;
      idle(3);
      chk("t1_ready", 32'(req_ready), 32'h1);
      chk("t1_resp_data", resp_data, 32'h0);

      foreach (tbl_a[i]) apply(tbl_a[i]);

      apply('{1'b1, 12'h050, 32'h55, 32'h0, 0});
      apply('{1'b0, 12'h010, 32'h0, 32'hDEADBEEF, 0});
      reset = 1'b0;
      @(posedge clock);
      #2;
      reset = 1'b1;
      idle(3);
      chk("t5_ready", 32'(req_ready), 32'h1);
      chk("t5_wb_count", 32'(wb_count), 32'h0);

      foreach (tbl_b[i]) apply(tbl_b[i]);

      idle(10);
      chk("pending_resp", 32'(eq.size()), 32'h0);
      chk("final_wb_count", 32'(wb_count), 32'h0);
      chk("final_busy", 32'(busy), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
